// File: rtl/alu_op_decoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_op_decoder_pkg : ALU op codes, RV32I opcodes and decoded-bundle layout
// Rev 1.0
// ----------------------------------------------------------------------------
package alu_op_decoder_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int ALU_W = 3;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_W-1:0] ALU_SLL = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SRL = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic             illegal;
    logic             is_branch;
    logic             reg_write;
    logic             alu_src_imm;
    logic [ALU_W-1:0] alu_control;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } dec_bundle_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode_comb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_op_decode_comb : pure combinational RV32I instr -> ALU bundle decode
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_op_decode_comb
  import alu_op_decoder_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output dec_bundle_t     o_bundle
);

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic             w_legal;
  logic [ALU_W-1:0] w_alu;
  logic [XLEN-1:0]  w_imm;
  logic             w_src_imm;
  logic             w_reg_write;
  logic             w_is_branch;
  logic [XLEN-1:0]  w_imm_i;
  logic [XLEN-1:0]  w_imm_s;
  logic [XLEN-1:0]  w_imm_b;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  assign w_imm_i = sext12(i_instr[31:20]);
  assign w_imm_s = sext12({i_instr[31:25], i_instr[11:7]});
  assign w_imm_b = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};

  always_comb begin
    w_legal     = 1'b0;
    w_alu       = ALU_ADD;
    w_imm       = '0;
    w_src_imm   = 1'b0;
    w_reg_write = 1'b0;
    w_is_branch = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          w_legal = 1'b1;
          case (w_funct3)
            3'b000:  w_alu = ALU_ADD;
            3'b111:  w_alu = ALU_AND;
            3'b110:  w_alu = ALU_OR;
            3'b100:  w_alu = ALU_XOR;
            3'b010:  w_alu = ALU_SLT;
            3'b001:  w_alu = ALU_SLL;
            3'b101:  w_alu = ALU_SRL;
            default: w_legal = 1'b0;
          endcase
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_legal = 1'b1;
          w_alu   = ALU_SUB;
        end
      end
      OP_I: begin
        w_reg_write = 1'b1;
        w_src_imm   = 1'b1;
        w_imm       = w_imm_i;
        w_legal     = 1'b1;
        case (w_funct3)
          3'b000:  w_alu = ALU_ADD;
          3'b111:  w_alu = ALU_AND;
          3'b110:  w_alu = ALU_OR;
          3'b100:  w_alu = ALU_XOR;
          3'b010:  w_alu = ALU_SLT;
          3'b001: begin
            w_alu   = ALU_SLL;
            w_legal = (w_funct7 == 7'b0000000);
          end
          3'b101: begin
            w_alu   = ALU_SRL;
            w_legal = (w_funct7 == 7'b0000000);
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        w_legal     = (w_funct3 == 3'b010);
        w_alu       = ALU_ADD;
        w_imm       = w_imm_i;
        w_src_imm   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_STORE: begin
        w_legal   = (w_funct3 == 3'b010);
        w_alu     = ALU_ADD;
        w_imm     = w_imm_s;
        w_src_imm = 1'b1;
      end
      OP_BRANCH: begin
        w_is_branch = 1'b1;
        w_imm       = w_imm_b;
        case (w_funct3)
          3'b000, 3'b001: begin
            w_legal = 1'b1;
            w_alu   = ALU_SUB;
          end
          3'b100, 3'b101: begin
            w_legal = 1'b1;
            w_alu   = ALU_SLT;
          end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal encodings carry only the register indices and the flag.
  always_comb begin
    o_bundle     = '0;
    o_bundle.rs1 = i_instr[19:15];
    o_bundle.rs2 = i_instr[24:20];
    o_bundle.rd  = i_instr[11:7];
    if (w_legal) begin
      o_bundle.alu_control = w_alu;
      o_bundle.imm         = w_imm;
      o_bundle.alu_src_imm = w_src_imm;
      o_bundle.reg_write   = w_reg_write;
      o_bundle.is_branch   = w_is_branch;
    end else begin
      o_bundle.illegal = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_op_decoder : registered RV32I decode stage with skid buffer and counter
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_op_decoder
  import alu_op_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALU_W-1:0]       alu_control,
  output logic                   alu_src_imm,
  output logic [XLEN-1:0]        imm,
  output logic [REG_W-1:0]       rs1,
  output logic [REG_W-1:0]       rs2,
  output logic [REG_W-1:0]       rd,
  output logic                   reg_write,
  output logic                   is_branch,
  output logic                   illegal,
  output logic [CNT_W-1:0]       illegal_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  buf_state_t        r_state;
  logic              r_out_valid;
  logic              r_in_ready;
  dec_bundle_t       r_out;
  dec_bundle_t       r_skid;
  logic [CNT_W-1:0]  r_count;

  dec_bundle_t       w_dec;
  logic              w_in_xfer;
  logic              w_out_xfer;

  alu_op_decode_comb u_decode (
    .i_instr  (instr),
    .o_bundle (w_dec)
  );

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out       <= '0;
      r_skid      <= '0;
      r_count     <= '0;
    end else begin
      if (w_out_xfer && r_out.illegal && !(&r_count))
        r_count <= r_count + 1'b1;
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_out <= w_dec;
          end else if (w_in_xfer) begin
            // Output stalled: park the new bundle and stop accepting.
            r_skid     <= w_dec;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            r_out      <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign alu_control   = r_out.alu_control;
  assign alu_src_imm   = r_out.alu_src_imm;
  assign imm           = r_out.imm;
  assign rs1           = r_out.rs1;
  assign rs2           = r_out.rs2;
  assign rd            = r_out.rd;
  assign reg_write     = r_out.reg_write;
  assign is_branch     = r_out.is_branch;
  assign illegal       = r_out.illegal;
  assign illegal_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_op_decoder : randomized bench against a queue-based reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        in_ready, out_valid, alu_src_imm, reg_write, is_branch, illegal;
  logic [2:0]  alu_control;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] illegal_count;

  logic        in_ready2, out_valid2, alu_src_imm2, reg_write2, is_branch2, illegal2;
  logic [2:0]  alu_control2;
  logic [31:0] imm2;
  logic [4:0]  rs1_2, rs2_2, rd_2;
  logic [1:0]  illegal_count2;

  always #5 clk = ~clk;

  alu_op_decoder #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .alu_src_imm(alu_src_imm), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
    .is_branch(is_branch), .illegal(illegal), .illegal_count(illegal_count)
  );

  alu_op_decoder #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .instr(instr), .out_valid(out_valid2), .out_ready(out_ready),
    .alu_control(alu_control2), .alu_src_imm(alu_src_imm2), .imm(imm2),
    .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .reg_write(reg_write2),
    .is_branch(is_branch2), .illegal(illegal2), .illegal_count(illegal_count2)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [53:0] q[$];
  int          mcnt;
  int          mcnt2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [53:0] dut_bundle();
    return {illegal, is_branch, reg_write, alu_src_imm, alu_control, imm, rs1, rs2, rd};
  endfunction

  // Reference decode: mnemonic-level table plus arithmetic immediates.
  function automatic logic [53:0] model(input logic [31:0] ins);
    int          op;
    bit          wr, src, br;
    int          immv;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] immu;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    op = -1; wr = 0; src = 0; br = 0; immv = 0;
    case (opc)
      7'h33: begin
        wr = 1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: op = 0; 3'd7: op = 2; 3'd6: op = 3; 3'd4: op = 4;
            3'd2: op = 5; 3'd1: op = 6; 3'd5: op = 7; default: op = -1;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
      end
      7'h13: begin
        wr = 1; src = 1;
        immv = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
        case (f3)
          3'd0: op = 0; 3'd7: op = 2; 3'd6: op = 3; 3'd4: op = 4; 3'd2: op = 5;
          3'd1: op = (f7 == 0) ? 6 : -1;
          3'd5: op = (f7 == 0) ? 7 : -1;
          default: op = -1;
        endcase
      end
      7'h03: if (f3 == 3'd2) begin
        op = 0; wr = 1; src = 1;
        immv = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
      end
      7'h23: if (f3 == 3'd2) begin
        op = 0; src = 1;
        immv = int'(ins[31:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 4096 : 0);
      end
      7'h63: begin
        br = 1;
        immv = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
               - (ins[31] ? 4096 : 0);
        if (f3 == 3'd0 || f3 == 3'd1) op = 1;
        else if (f3 == 3'd4 || f3 == 3'd5) op = 5;
      end
      default: op = -1;
    endcase
    if (op < 0)
      return {4'b1000, 3'b000, 32'h0, ins[19:15], ins[24:20], ins[11:7]};
    immu = immv;
    return {1'b0, br, wr, src, op[2:0], immu, ins[19:15], ins[24:20], ins[11:7]};
  endfunction

  // One cycle: check outputs against the model, drive inputs, advance model.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      output logic acc);
    @(negedge clk);
    check("out_valid", {63'b0, out_valid}, {63'b0, q.size() > 0});
    check("in_ready", {63'b0, in_ready}, {63'b0, q.size() < 2});
    check("count", {48'b0, illegal_count}, mcnt);
    check("count_w2", {62'b0, illegal_count2}, mcnt2);
    if (q.size() > 0) check("bundle", {10'b0, dut_bundle()}, {10'b0, q[0]});
    in_valid  = v;
    instr     = ins;
    out_ready = ordy;
    acc = v && (q.size() < 2);
    if (ordy && q.size() > 0) begin
      if (q[0][53]) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
      void'(q.pop_front());
    end
    if (acc) q.push_back(model(ins));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    case ($urandom_range(0, 6))
      0: opc = 7'h33; 1: opc = 7'h13; 2: opc = 7'h03; 3: opc = 7'h23;
      4: opc = 7'h63; 5: opc = 7'h33; default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 2))
      0: f7 = 7'h00; 1: f7 = 7'h20; default: f7 = 7'($urandom);
    endcase
    f3 = 3'($urandom);
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
  endfunction

  initial begin
    logic        acc;
    logic        pend_v;
    logic [31:0] pend_i;
    logic [31:0] stream[4];
    int          idx;

    rst_n = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    mcnt = 0; mcnt2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_count", {48'b0, illegal_count}, 64'd0);
    check("rst_bundle", {10'b0, dut_bundle()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode cases
    step(1'b1, 32'h402081B3, 1'b1, acc);
    @(posedge clk); #1;
    check("sub_alu", {61'b0, alu_control}, 64'd1);
    check("sub_regs", {49'b0, rs1, rs2, rd}, {49'b0, 5'd1, 5'd2, 5'd3});
    check("sub_ctl", {62'b0, reg_write, alu_src_imm}, 64'b10);
    step(1'b1, 32'hFFF00293, 1'b1, acc);
    @(posedge clk); #1;
    check("addi_imm", {32'b0, imm}, 64'hFFFFFFFF);
    check("addi_ctl", {56'b0, alu_control, alu_src_imm, rd}, {56'b0, 3'd0, 1'b1, 5'd5});
    step(1'b1, 32'h0020A423, 1'b1, acc);
    @(posedge clk); #1;
    check("sw_imm", {32'b0, imm}, 64'd8);
    check("sw_ctl", {60'b0, alu_control, reg_write}, 64'd0);
    step(1'b1, 32'hFE20CEE3, 1'b1, acc);
    @(posedge clk); #1;
    check("blt_imm", {32'b0, imm}, 64'hFFFFFFFC);
    check("blt_ctl", {60'b0, alu_control, is_branch}, {60'b0, 3'd5, 1'b1});
    step(1'b0, 32'h0, 1'b1, acc);

    // Back-to-back stream with a 3-cycle downstream stall
    stream[0] = 32'h00108133; stream[1] = 32'h0030F213;
    stream[2] = 32'h00412303; stream[3] = 32'h00532423;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) step(1'b1, stream[idx], c >= 3, acc);
      else         step(1'b0, 32'h0, 1'b1, acc);
      if (acc) idx++;
    end
    check("stream_acc", idx, 64'd4);

    // Illegal encodings and counter saturation
    step(1'b1, 32'h4020D1B3, 1'b1, acc);
    @(posedge clk); #1;
    check("sra_ctl", {58'b0, illegal, alu_control, reg_write, is_branch},
          {58'b0, 1'b1, 3'd0, 1'b0, 1'b0});
    step(1'b1, 32'h0000007F, 1'b1, acc);
    step(1'b0, 32'h0, 1'b1, acc);
    @(posedge clk); #1;
    check("ill_cnt2", {48'b0, illegal_count}, 64'd2);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h4020D1B3, 1'b1, acc);
    step(1'b0, 32'h0, 1'b1, acc);
    @(posedge clk); #1;
    check("ill_cnt5", {48'b0, illegal_count}, 64'd5);
    check("ill_sat_w2", {62'b0, illegal_count2}, 64'd3);

    // Random traffic; source holds an unaccepted instr
    pend_v = 1'b0; pend_i = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 3) != 0);
        pend_i = rand_instr();
      end
      step(pend_v, pend_i, $urandom_range(0, 9) < 7, acc);
      if (acc) pend_v = 1'b0;
    end

    // Asynchronous reset with the buffer full
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, acc);
    step(1'b1, 32'h0000007F, 1'b0, acc);
    step(1'b1, 32'h402081B3, 1'b0, acc);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'b0, out_valid}, 64'd0);
    check("arst_count", {48'b0, illegal_count}, 64'd0);
    check("arst_in_ready", {63'b0, in_ready}, 64'd1);
    check("arst_bundle", {10'b0, dut_bundle()}, 64'd0);
    q.delete(); mcnt = 0; mcnt2 = 0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    pend_v = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 1) != 0);
        pend_i = rand_instr();
      end
      step(pend_v, pend_i, $urandom_range(0, 1) == 1, acc);
      if (acc) pend_v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
